// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect
// Input-conditioning stage. It brings a raw asynchronous level into the clk
// domain and filters out bounces. It produces a clean registered level (q),
// one-cycle rise/fall pulses on accepted transitions, and a busy flag that is
// high while a candidate level change is being qualified.
// A companion checker module at the end of this file holds the structural
// assertions. Synthesis treats that checker as logic-free.

module debounce_edge_detect #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  // FSM state encoding
  localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  // Counter constants, sized to the counter width
  localparam logic [CNT_W-1:0] LP_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // With a single-sample requirement, a new level is accepted straight from IDLE
  localparam bit LP_SINGLE = (STABLE_CYCLES == 1);

  // Synchroniser chain; only the last stage is ever observed
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  // FSM registers
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_q_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_busy_nxt;

  // Observation taps for the checker
  logic w_in_wait_high;
  logic w_in_wait_low;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Qualification FSM: compute next state, counter, level and pulses from s
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_IDLE_LOW: begin
        if (w_s) begin
          if (LP_SINGLE) begin
            w_state_nxt = ST_IDLE_HIGH;
            w_q_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = LP_CNT_ZERO;
          end else begin
            w_state_nxt = ST_WAIT_HIGH;
            w_cnt_nxt   = LP_CNT_ONE;
          end
        end else begin
          w_cnt_nxt = LP_CNT_ZERO;
        end
      end
      ST_WAIT_HIGH: begin
        if (!w_s) begin
          // Opposite sample: drop the candidate silently
          w_state_nxt = ST_IDLE_LOW;
          w_cnt_nxt   = LP_CNT_ZERO;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_IDLE_HIGH;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
          w_cnt_nxt   = LP_CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      ST_IDLE_HIGH: begin
        if (!w_s) begin
          if (LP_SINGLE) begin
            w_state_nxt = ST_IDLE_LOW;
            w_q_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = LP_CNT_ZERO;
          end else begin
            w_state_nxt = ST_WAIT_LOW;
            w_cnt_nxt   = LP_CNT_ONE;
          end
        end else begin
          w_cnt_nxt = LP_CNT_ZERO;
        end
      end
      ST_WAIT_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_IDLE_HIGH;
          w_cnt_nxt   = LP_CNT_ZERO;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_IDLE_LOW;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
          w_cnt_nxt   = LP_CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        // Unreachable encoding: fall back to the reset state
        w_state_nxt = ST_IDLE_LOW;
        w_q_nxt     = 1'b0;
        w_cnt_nxt   = LP_CNT_ZERO;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_WAIT_HIGH) || (w_state_nxt == ST_WAIT_LOW);
  end

  // Register FSM state and all outputs; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE_LOW;
      r_cnt   <= LP_CNT_ZERO;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

  assign w_in_wait_high = (r_state == ST_WAIT_HIGH);
  assign w_in_wait_low  = (r_state == ST_WAIT_LOW);

  debounce_edge_detect_chk #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .in_wait_high (w_in_wait_high),
    .in_wait_low  (w_in_wait_low),
    .cnt          (r_cnt),
    .q            (r_q),
    .rise         (r_rise),
    .fall         (r_fall),
    .busy         (r_busy)
  );

endmodule

// debounce_edge_detect_chk
// Structural invariants of the debouncer: pulse exclusivity, counter bound,
// q frozen while qualifying, and busy tracking the WAIT states.
module debounce_edge_detect_chk #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             in_wait_high,
  input logic             in_wait_low,
  input logic [CNT_W-1:0] cnt,
  input logic             q,
  input logic             rise,
  input logic             fall,
  input logic             busy
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  a_params: assert property (@(posedge clk)
    (SYNC_STAGES >= 2) && (STABLE_CYCLES >= 1) && (STABLE_CYCLES <= (2 ** CNT_W) - 1));

  a_pulse_excl: assert property (@(posedge clk) disable iff (rst) !(rise && fall));

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= LP_CNT_LAST);

  a_wait_high_q: assert property (@(posedge clk) disable iff (rst) in_wait_high |-> !q);

  a_wait_low_q: assert property (@(posedge clk) disable iff (rst) in_wait_low |-> q);

  a_busy_state: assert property (@(posedge clk) disable iff (rst)
    busy == (in_wait_high || in_wait_low));

  a_rise_level: assert property (@(posedge clk) disable iff (rst) rise |-> q);

  a_fall_level: assert property (@(posedge clk) disable iff (rst) fall |-> !q);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// tb_debounce_edge_detect
// Drives two debouncers from one stimulus stream: defaults (STABLE_CYCLES=4)
// and STABLE_CYCLES=1. A behavioural model predicts each cycle's outputs. The
// model treats the synchroniser as a pure delay line and uses a run-length
// counter of samples that disagree with the current level. A monitor pops
// the predictions and compares them after every clock edge.

module tb_debounce_edge_detect;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic q_a, rise_a, fall_a, busy_a;
  logic q_b, rise_b, fall_b, busy_b;

  // Clock generation
  always #5 clk = ~clk;

  debounce_edge_detect #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .din(din), .q(q_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  debounce_edge_detect #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .din(din), .q(q_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  // Scoreboard queues: {q, rise, fall, busy} expected after the next edge
  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];

  int  n_vec  = 0;
  int  n_err  = 0;
  int  n_cyc  = 0;
  bit  running = 1'b0;
  int  n_rise_a = 0, n_fall_a = 0, n_rise_b = 0, n_fall_b = 0;

  // Reference model state, one slot per DUT
  bit m_dly [2][SYNC];
  bit m_q   [2];
  int m_run [2];
  int m_need[2];

  task automatic model_step(input bit d, input bit r);
    for (int k = 0; k < 2; k++) begin
      bit s;
      bit ri;
      bit fa;
      ri = 1'b0;
      fa = 1'b0;
      if (r) begin
        for (int j = 0; j < SYNC; j++) m_dly[k][j] = 1'b0;
        m_q[k]   = 1'b0;
        m_run[k] = 0;
      end else begin
        s = m_dly[k][SYNC-1];
        for (int j = SYNC - 1; j > 0; j--) m_dly[k][j] = m_dly[k][j-1];
        m_dly[k][0] = d;
        if (s != m_q[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == m_need[k]) begin
            m_q[k]   = s;
            ri       = s;
            fa       = !s;
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      if (k == 0) exp_a.push_back({m_q[k], ri, fa, (m_run[k] != 0)});
      else        exp_b.push_back({m_q[k], ri, fa, (m_run[k] != 0)});
    end
  endtask

  // Drive one cycle of stimulus away from the active edge and predict
  task automatic step(input bit d, input bit r);
    @(negedge clk);
    din = d;
    rst = r;
    running = 1'b1;
    model_step(d, r);
  endtask

  task automatic run(input bit d, input bit r, input int n);
    for (int i = 0; i < n; i++) step(d, r);
  endtask

  task automatic check_count(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard after every edge
  always @(posedge clk) begin
    #1;
    if (rise_a) n_rise_a++;
    if (fall_a) n_fall_a++;
    if (rise_b) n_rise_b++;
    if (fall_b) n_fall_b++;
    if (running) begin
      n_cyc++;
      n_vec += 2;
      if (exp_a.size() == 0 || exp_b.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty cyc %0d: got no expectation, expected one per DUT", n_cyc);
      end else begin
        logic [3:0] ea;
        logic [3:0] eb;
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        if ({q_a, rise_a, fall_a, busy_a} !== ea) begin
          n_err++;
          $display("FAIL stable4 cyc %0d: got q/rise/fall/busy=%b, expected %b",
                   n_cyc, {q_a, rise_a, fall_a, busy_a}, ea);
        end
        if ({q_b, rise_b, fall_b, busy_b} !== eb) begin
          n_err++;
          $display("FAIL stable1 cyc %0d: got q/rise/fall/busy=%b, expected %b",
                   n_cyc, {q_b, rise_b, fall_b, busy_b}, eb);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized runs
  initial begin
    int base_r;
    int base_f;
    int base_rb;
    int base_fb;
    rst = 1'b1;
    din = 1'b0;
    m_need[0] = 4;
    m_need[1] = 1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < SYNC; j++) m_dly[k][j] = 1'b0;
      m_q[k]   = 1'b0;
      m_run[k] = 0;
    end

    // Reset held with din=1, then release with din still high
    run(1'b1, 1'b1, 4);
    run(1'b1, 1'b0, 10);

    // Glitch of 3 cycles from q=0
    run(1'b0, 1'b0, 10);
    base_r = n_rise_a;
    run(1'b1, 1'b0, 3);
    run(1'b0, 1'b0, 10);
    check_count("glitch_no_rise", n_rise_a - base_r, 0);

    // Clean fall from q=1
    run(1'b1, 1'b0, 10);
    base_f = n_fall_a;
    run(1'b0, 1'b0, 10);
    check_count("fall_single_pulse", n_fall_a - base_f, 1);

    // Bounce: toggles for 8 cycles then holds high
    base_r = n_rise_a;
    for (int i = 0; i < 8; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
    run(1'b1, 1'b0, 12);
    check_count("bounce_one_rise", n_rise_a - base_r, 1);

    // Reset in the middle of qualification, then full requalification
    run(1'b0, 1'b0, 10);
    run(1'b1, 1'b0, 4);
    run(1'b1, 1'b1, 1);
    run(1'b1, 1'b0, 10);

    // Single-cycle pulse: accepted only by the STABLE_CYCLES=1 instance
    run(1'b0, 1'b0, 8);
    base_r  = n_rise_a;
    base_rb = n_rise_b;
    base_fb = n_fall_b;
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b0, 8);
    check_count("pulse_stable1_rise", n_rise_b - base_rb, 1);
    check_count("pulse_stable1_fall", n_fall_b - base_fb, 1);
    check_count("pulse_stable4_no_rise", n_rise_a - base_r, 0);

    // Randomized runs of random length, with occasional resets
    for (int i = 0; i < 300; i++) begin
      bit v;
      int len;
      v   = 1'($urandom_range(1, 0));
      len = int'($urandom_range(8, 1));
      if ($urandom_range(39, 0) == 0) run(v, 1'b1, int'($urandom_range(3, 1)));
      run(v, 1'b0, len);
    end
    run(1'b0, 1'b0, 8);

    @(posedge clk);
    #2;
    running = 1'b0;
    check_count("scoreboard_drained_a", exp_a.size(), 0);
    check_count("scoreboard_drained_b", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
